// File: rtl/tmds_align_pkg.sv
// Shared definitions for the TMDS word-alignment controller.
//   - WordW: deserialized word width
//   - TokCtl0..TokCtl3: the four TMDS control-period tokens
//   - align_state_e: alignment FSM states
//   - is_token(): word matches any control token
//   - cnt_width(): bit width needed to hold 0..max_val
package tmds_align_pkg;

  localparam int unsigned WordW = 10;

  localparam logic [WordW-1:0] TokCtl0 = 10'h354;
  localparam logic [WordW-1:0] TokCtl1 = 10'h0AB;
  localparam logic [WordW-1:0] TokCtl2 = 10'h154;
  localparam logic [WordW-1:0] TokCtl3 = 10'h2AB;

  typedef enum logic [2:0] {
    StIdle,
    StSearch,
    StCalib,
    StSettle,
    StLocked,
    StFail
  } align_state_e;

  function automatic logic is_token(input logic [WordW-1:0] word);
    return (word == TokCtl0) || (word == TokCtl1) || (word == TokCtl2) || (word == TokCtl3);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/tmds_token_detect.sv
// Registered TMDS control-token detector.
// Ports:
//   clk       in   word clock
//   rst       in   synchronous active-high reset
//   data_in   in   deserialized 10-bit word
//   token_hit out  registered: previous-cycle word was a control token
module tmds_token_detect
  import tmds_align_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [WordW-1:0] data_in,
  output logic             token_hit
);

  always_ff @(posedge clk) begin
    if (rst) begin
      token_hit <= 1'b0;
    end else begin
      token_hit <= is_token(data_in);
    end
  end

endmodule

// File: rtl/tmds_word_align.sv
// TMDS word-alignment controller (word clock domain).
// Searches for control tokens at the current word boundary and pulses the
// CLKDIV calib input to slip the boundary by one bit when none are found.
// Ports:
//   clk        in   divided word clock (CLKDIV clkout)
//   rst        in   synchronous active-high reset
//   en         in   enable; low forces IDLE
//   data_in    in   deserialized 10-bit word, LSB first in time
//   calib      out  one-cycle slip pulse to CLKDIV calib
//   locked     out  word boundary aligned
//   align_fail out  high while a failed sweep is cooling down
//   slip_count out  slips issued in the current sweep (saturating)
// Optional feature macro: TMDS_ALIGN_RELOCK_EN -- when defined, LOCKED is left
// after LOSS_CYCLES consecutive token-free words and the search resumes with
// slip_count preserved. Otherwise LOCKED is sticky until rst or en low.
module tmds_word_align
  import tmds_align_pkg::*;
#(
  parameter int unsigned MATCH_CNT     = 16,
  parameter int unsigned SEARCH_CYCLES = 64,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned MAX_SLIPS     = 10,
  parameter int unsigned LOSS_CYCLES   = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WordW-1:0] data_in,
  output logic             calib,
  output logic             locked,
  output logic             align_fail,
  output logic [3:0]       slip_count
);

  localparam int unsigned MatchW  = cnt_width(MATCH_CNT);
  localparam int unsigned SearchW = cnt_width(SEARCH_CYCLES - 1);
  localparam int unsigned SettleW = cnt_width(SETTLE_CYCLES - 1);

  localparam logic [MatchW-1:0]  MatchTerm  = MatchW'(MATCH_CNT);
  localparam logic [SearchW-1:0] SearchTerm = SearchW'(SEARCH_CYCLES - 1);
  localparam logic [SettleW-1:0] SettleTerm = SettleW'(SETTLE_CYCLES - 1);
  localparam logic [3:0]         SlipTerm   = 4'(MAX_SLIPS);

  align_state_e       state_q, state_d;
  logic [MatchW-1:0]  match_cnt_q, match_cnt_d;
  logic [SearchW-1:0] search_cnt_q, search_cnt_d;
  logic [SettleW-1:0] settle_cnt_q, settle_cnt_d;
  logic [3:0]         slip_cnt_q, slip_cnt_d;
  logic               token_hit;

`ifdef TMDS_ALIGN_RELOCK_EN
  localparam int unsigned LossW = cnt_width(LOSS_CYCLES);
  localparam logic [LossW-1:0] LossTerm = LossW'(LOSS_CYCLES);
  logic [LossW-1:0] loss_cnt_q, loss_cnt_d;
`else
  logic unused_loss_cfg;
  assign unused_loss_cfg = ^LOSS_CYCLES;
`endif

  tmds_token_detect u_token_detect (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .token_hit (token_hit)
  );

  always_comb begin
    state_d      = state_q;
    match_cnt_d  = match_cnt_q;
    search_cnt_d = search_cnt_q;
    settle_cnt_d = settle_cnt_q;
    slip_cnt_d   = slip_cnt_q;
`ifdef TMDS_ALIGN_RELOCK_EN
    loss_cnt_d   = loss_cnt_q;
`endif

    if (!en) begin
      state_d      = StIdle;
      match_cnt_d  = '0;
      search_cnt_d = '0;
      settle_cnt_d = '0;
      slip_cnt_d   = '0;
`ifdef TMDS_ALIGN_RELOCK_EN
      loss_cnt_d   = '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d      = StSearch;
          match_cnt_d  = '0;
          search_cnt_d = '0;
          settle_cnt_d = '0;
          slip_cnt_d   = '0;
        end

        StSearch: begin
          if (token_hit) begin
            if (match_cnt_q != MatchTerm) match_cnt_d = match_cnt_q + MatchW'(1);
          end else begin
            match_cnt_d = '0;
          end
          if (search_cnt_q != SearchTerm) search_cnt_d = search_cnt_q + SearchW'(1);

          // Lock check wins over the search timeout when both land together.
          if (match_cnt_q == MatchTerm) begin
            state_d      = StLocked;
            match_cnt_d  = '0;
            search_cnt_d = '0;
          end else if (search_cnt_q == SearchTerm) begin
            match_cnt_d  = '0;
            search_cnt_d = '0;
            if (slip_cnt_q < SlipTerm) begin
              state_d    = StCalib;
              slip_cnt_d = slip_cnt_q + 4'd1;
            end else begin
              state_d = StFail;
            end
          end
        end

        StCalib: begin
          state_d      = StSettle;
          settle_cnt_d = '0;
        end

        // Words are discarded here while the divider re-phases its output.
        StSettle: begin
          if (settle_cnt_q == SettleTerm) begin
            state_d      = StSearch;
            settle_cnt_d = '0;
            search_cnt_d = '0;
            match_cnt_d  = '0;
          end else begin
            settle_cnt_d = settle_cnt_q + SettleW'(1);
          end
        end

        StLocked: begin
`ifdef TMDS_ALIGN_RELOCK_EN
          if (loss_cnt_q == LossTerm) begin
            state_d      = StSearch;
            loss_cnt_d   = '0;
            search_cnt_d = '0;
            match_cnt_d  = '0;
          end else if (token_hit) begin
            loss_cnt_d = '0;
          end else begin
            loss_cnt_d = loss_cnt_q + LossW'(1);
          end
`endif
        end

        // FAIL dwell has the same length as a search window, so the search
        // counter times it.
        StFail: begin
          if (search_cnt_q == SearchTerm) begin
            state_d      = StSearch;
            search_cnt_d = '0;
            match_cnt_d  = '0;
            slip_cnt_d   = '0;
          end else begin
            search_cnt_d = search_cnt_q + SearchW'(1);
          end
        end

        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      match_cnt_q  <= '0;
      search_cnt_q <= '0;
      settle_cnt_q <= '0;
      slip_cnt_q   <= '0;
      calib        <= 1'b0;
      locked       <= 1'b0;
      align_fail   <= 1'b0;
    end else begin
      state_q      <= state_d;
      match_cnt_q  <= match_cnt_d;
      search_cnt_q <= search_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      slip_cnt_q   <= slip_cnt_d;
      // Outputs registered from the next state so they align with it.
      calib        <= (state_d == StCalib);
      locked       <= (state_d == StLocked);
      align_fail   <= (state_d == StFail);
    end
  end

`ifdef TMDS_ALIGN_RELOCK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      loss_cnt_q <= '0;
    end else begin
      loss_cnt_q <= loss_cnt_d;
    end
  end
`endif

  assign slip_count = slip_cnt_q;

endmodule
